// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, the invalid tag and the arbiter FSM states.
package cdb_pkg;

    localparam int CDB_TAG_W  = 5;
    localparam int CDB_DATA_W = 32;

    // All-ones tag: "no producer", never a live reservation-station tag.
    localparam logic [CDB_TAG_W-1:0] INVALID_TAG = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BCAST = 2'd1,
        GAP   = 2'd2
    } cdb_state_e;

    // Width of a unit index; at least one bit so a single-unit build still has a pointer.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first eligible unit strictly after ptr_i, wrapping to 0.
module rr_picker
    import cdb_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int PTR_W     = ptr_width(NUM_UNITS)
) (
    input  logic [NUM_UNITS-1:0] elig_i,
    input  logic [PTR_W-1:0]     ptr_i,
    output logic [NUM_UNITS-1:0] win_o,
    output logic                 valid_o
);

    logic [PTR_W-1:0] idx;
    logic             found;

    // NOTE: every variable written here gets a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        win_o = '0;
        found = 1'b0;
        idx   = '0;
        for (int off = 1; off <= NUM_UNITS; off++) begin
            idx = PTR_W'((int'(ptr_i) + off) % NUM_UNITS);
            if (!found && elig_i[idx]) begin
                win_o[idx] = 1'b1;
                found      = 1'b1;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: IDLE -> BCAST (one cycle) -> GAP (one cycle), round-robin winner.
// Optional macro CDB_TAG_CHECK_EN: suppress broadcast of INVALID_TAG and raise sticky out_err.
module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int TAG_W     = CDB_TAG_W,
    parameter int DATA_W    = CDB_DATA_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_UNITS-1:0]          in_req,
    input  logic [NUM_UNITS*TAG_W-1:0]    in_tag,
    input  logic [NUM_UNITS*DATA_W-1:0]   in_val,
    output logic [NUM_UNITS-1:0]          out_grant,
    output logic                          out_CDB_broadcast,
    output logic [TAG_W-1:0]              out_CDB_tag,
    output logic [DATA_W-1:0]             out_CDB_val,
    output logic                          out_busy
`ifdef CDB_TAG_CHECK_EN
    ,
    output logic                          out_err
`endif
);

    localparam int               PTR_W    = ptr_width(NUM_UNITS);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_UNITS - 1);
    // INVALID_TAG generalised to TAG_W: all ones at any width.
    localparam logic [TAG_W-1:0] TAG_NONE = '1;

    cdb_state_e             state_q, state_d;
    logic [PTR_W-1:0]       ptr_q, ptr_d;
    logic [NUM_UNITS-1:0]   grant_q, grant_d;
    logic                   bcast_q, bcast_d;
    logic [TAG_W-1:0]       tag_q, tag_d;
    logic [DATA_W-1:0]      val_q, val_d;

    logic [NUM_UNITS-1:0]   elig;
    logic [NUM_UNITS-1:0]   win;
    logic                   win_valid;
    logic [PTR_W-1:0]       win_idx;
    logic [TAG_W-1:0]       win_tag;
    logic [DATA_W-1:0]      win_val;
    logic                   tag_bad;
    logic                   select;

    // The unit currently holding the grant must not win again off its stale request.
    assign elig = in_req & ~grant_q;

    rr_picker #(
        .NUM_UNITS (NUM_UNITS),
        .PTR_W     (PTR_W)
    ) u_picker (
        .elig_i  (elig),
        .ptr_i   (ptr_q),
        .win_o   (win),
        .valid_o (win_valid)
    );

    always_comb begin : winner_mux
        win_idx = '0;
        win_tag = '0;
        win_val = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (win[i]) begin
                win_idx = PTR_W'(i);
                win_tag = in_tag[i*TAG_W +: TAG_W];
                win_val = in_val[i*DATA_W +: DATA_W];
            end
        end
    end

`ifdef CDB_TAG_CHECK_EN
    assign tag_bad = (win_tag == TAG_NONE);
`else
    assign tag_bad = 1'b0;
`endif

    assign select = win_valid && (state_q == IDLE || state_q == GAP);

    always_comb begin : next_state
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = '0;
        bcast_d = 1'b0;
        tag_d   = TAG_NONE;
        val_d   = '0;
        unique case (state_q)
            IDLE, GAP: begin
                if (select) begin
                    state_d = BCAST;
                    ptr_d   = win_idx;
                    grant_d = win;
                    if (!tag_bad) begin
                        bcast_d = 1'b1;
                        tag_d   = win_tag;
                        val_d   = win_val;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            // Broadcast lasts one cycle; the gap gives consumers a fresh rising edge.
            BCAST:   state_d = GAP;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= PTR_RST;
            grant_q <= '0;
            bcast_q <= 1'b0;
            tag_q   <= TAG_NONE;
            val_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            bcast_q <= bcast_d;
            tag_q   <= tag_d;
            val_q   <= val_d;
        end
    end

`ifdef CDB_TAG_CHECK_EN
    logic err_q, err_d;

    assign err_d = err_q | (select & tag_bad);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign out_err = err_q;
`endif

    assign out_grant         = grant_q;
    assign out_CDB_broadcast = bcast_q;
    assign out_CDB_tag       = tag_q;
    assign out_CDB_val       = val_q;
    assign out_busy          = (state_q != IDLE);

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: directed scenarios plus randomized requesters against a timing/priority model.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int N  = 4;
    localparam int TW = 5;
    localparam int DW = 32;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      in_req;
    logic [N*TW-1:0]   in_tag;
    logic [N*DW-1:0]   in_val;
    logic [N-1:0]      out_grant;
    logic              out_CDB_broadcast;
    logic [TW-1:0]     out_CDB_tag;
    logic [DW-1:0]     out_CDB_val;
    logic              out_busy;
`ifdef CDB_TAG_CHECK_EN
    logic              out_err;
`endif

    // Requester-side stimulus, one entry per unit.
    logic              req_a [N];
    logic [TW-1:0]     tag_a [N];
    logic [DW-1:0]     val_a [N];

    for (genvar u = 0; u < N; u++) begin : g_pack
        assign in_req[u]            = req_a[u];
        assign in_tag[u*TW +: TW]   = tag_a[u];
        assign in_val[u*DW +: DW]   = val_a[u];
    end

    cdb_arbiter #(
        .NUM_UNITS (N),
        .TAG_W     (TW),
        .DATA_W    (DW)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .in_req            (in_req),
        .in_tag            (in_tag),
        .in_val            (in_val),
        .out_grant         (out_grant),
        .out_CDB_broadcast (out_CDB_broadcast),
        .out_CDB_tag       (out_CDB_tag),
        .out_CDB_val       (out_CDB_val),
        .out_busy          (out_busy)
`ifdef CDB_TAG_CHECK_EN
        ,
        .out_err           (out_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: edge counter, edge of the last grant, last granted unit, sticky error.
    int cyc;
    int last_gnt;
    int last_unit;
    int granted_unit;
    bit err_m;
    bit prev_b;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic clear_units();
        for (int u = 0; u < N; u++) begin
            req_a[u] = 1'b0;
            tag_a[u] = '0;
            val_a[u] = '0;
        end
    endtask

    task automatic set_unit(input int u, input logic [TW-1:0] t, input logic [DW-1:0] v);
        req_a[u] = 1'b1;
        tag_a[u] = t;
        val_a[u] = v;
    endtask

    // Called at a falling edge; asserts reset, checks the immediate effect, releases a cycle later.
    task automatic apply_reset(input string nm);
        rst_n = 1'b0;
        #1;
        check({nm, "_rst_grant"}, out_grant, '0);
        check({nm, "_rst_bcast"}, out_CDB_broadcast, 0);
        check({nm, "_rst_tag"}, out_CDB_tag, INVALID_TAG);
        check({nm, "_rst_val"}, out_CDB_val, 0);
        check({nm, "_rst_busy"}, out_busy, 0);
`ifdef CDB_TAG_CHECK_EN
        check({nm, "_rst_err"}, out_err, 0);
`endif
        clear_units();
        cyc          = 0;
        last_gnt     = -100;
        last_unit    = N - 1;
        granted_unit = -1;
        err_m        = 1'b0;
        prev_b       = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock: inputs already driven at a falling edge; model the edge, check, return at next falling edge.
    task automatic tick();
        int           win;
        int           best;
        bit           gr;
        bit           exp_b;
        bit           exp_busy;
        logic [N-1:0] exp_grant;
        @(posedge clk);
        cyc++;
        win  = -1;
        best = N;
        // A new grant needs one full idle (gap) cycle since the previous one.
        if (cyc - last_gnt >= 2) begin
            for (int u = 0; u < N; u++) begin
                if (req_a[u]) begin
                    int d;
                    d = (u - last_unit - 1 + 2 * N) % N;
                    if (d < best) begin
                        best = d;
                        win  = u;
                    end
                end
            end
        end
        gr = (win >= 0);
        exp_grant = '0;
        if (gr) begin
            last_gnt  = cyc;
            last_unit = win;
            exp_grant[win] = 1'b1;
        end
        granted_unit = win;
        exp_b = gr;
`ifdef CDB_TAG_CHECK_EN
        if (gr && tag_a[win] == INVALID_TAG) begin
            exp_b = 1'b0;
            err_m = 1'b1;
        end
`endif
        exp_busy = (cyc - last_gnt) <= 1;
        #1;
        check("grant", out_grant, exp_grant);
        check("bcast", out_CDB_broadcast, exp_b);
        check("tag", out_CDB_tag, exp_b ? tag_a[win] : INVALID_TAG);
        if (exp_b) check("val", out_CDB_val, val_a[win]);
        if (!exp_busy) check("idle_val", out_CDB_val, 0);
        check("busy", out_busy, exp_busy);
        check("grant_onehot0", $onehot0(out_grant), 1);
        check("bcast_b2b", prev_b & out_CDB_broadcast, 0);
`ifdef CDB_TAG_CHECK_EN
        check("err", out_err, err_m);
`endif
        prev_b = out_CDB_broadcast;
        @(negedge clk);
    endtask

    initial begin
        logic [N-1:0] exp_g;
        rst_n = 1'b0;
        clear_units();
        @(negedge clk);
        apply_reset("por");

        // Idle with no requests stays quiet.
        repeat (3) tick();
        check("idle_busy", out_busy, 0);

        // Single request: unit 2, tag 3, value 6.
        set_unit(2, 5'd3, 32'h6);
        tick();
        check("single_grant", out_grant, 4'b0100);
        check("single_tag", out_CDB_tag, 5'd3);
        check("single_val", out_CDB_val, 32'h6);
        req_a[2] = 1'b0;
        tick();
        check("single_gap_bcast", out_CDB_broadcast, 0);
        check("single_gap_busy", out_busy, 1);
        tick();
        check("single_idle_busy", out_busy, 0);

        // All four units requesting continuously from reset.
        apply_reset("rr");
        for (int u = 0; u < N; u++) set_unit(u, TW'(u + 8), DW'(u * 16 + 1));
        for (int t = 1; t <= 9; t++) begin
            tick();
            exp_g = '0;
            if (t % 2 == 1) exp_g[((t - 1) / 2) % N] = 1'b1;
            check("rr_order", out_grant, exp_g);
        end

        // Units 1 and 3 requesting after unit 1 was last granted.
        apply_reset("skip");
        set_unit(1, 5'd10, 32'hA);
        tick();
        check("skip_pre", out_grant, 4'b0010);
        req_a[1] = 1'b0;
        tick();
        tick();
        set_unit(1, 5'd11, 32'hB);
        set_unit(3, 5'd13, 32'hD);
        tick();
        check("skip_first", out_grant, 4'b1000);
        req_a[3] = 1'b0;
        tick();
        tick();
        check("skip_second", out_grant, 4'b0010);
        req_a[1] = 1'b0;
        tick();
        tick();

        // Reset asserted in the middle of a broadcast.
        apply_reset("pre_mid");
        set_unit(0, 5'd7, 32'h77);
        tick();
        check("mid_precond", out_CDB_broadcast, 1);
        apply_reset("mid");

`ifdef CDB_TAG_CHECK_EN
        // Invalid tag: granted but not broadcast, sticky error.
        set_unit(0, 5'b11111, 32'h5);
        tick();
        check("inv_grant", out_grant, 4'b0001);
        check("inv_bcast", out_CDB_broadcast, 0);
        check("inv_err", out_err, 1);
        req_a[0] = 1'b0;
        tick();
        tick();
        check("inv_err_sticky", out_err, 1);
        apply_reset("inv");
`endif

        // Randomized requesters obeying the hold-until-grant protocol.
        for (int k = 0; k < 800; k++) begin
            for (int u = 0; u < N; u++) begin
                if (u == granted_unit) begin
                    if ($urandom_range(0, 3) == 0) set_unit(u, TW'($urandom), $urandom);
                    else req_a[u] = 1'b0;
                end else if (!req_a[u] && $urandom_range(0, 2) == 0) begin
                    set_unit(u, TW'($urandom), $urandom);
                end
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
